// File: rtl/inv_loop_pkg.sv
// Shared types and constants for the inverter-loop stimulus/check stage.
package inv_loop_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    TOGGLE,
    MEASURE,
    HOLD,
    NEXT,
    FINISH
  } state_t;

  localparam logic [7:0] ERR_MAX = 8'hFF;

  // Error counter increment that sticks at ERR_MAX instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == ERR_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/inv_loop_sync.sv
// Multi-flop synchronizer for the asynchronous inverter response.
module inv_loop_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] r_chain;

  // NOTE: sequential state is written with <= so every flop samples the pre-edge value of its neighbour.
  always_ff @(posedge clk) begin
    if (rst) r_chain <= '0;
    else     r_chain <= {r_chain[SYNC_STAGES-2:0], d};
  end

  assign q = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/inv_loop_checker.sv
// Toggles stim_out into the analog double inverter and times each returned edge.
// Define INV_LOOP_MAXDLY_EN to track the largest matched delay on max_delay.
module inv_loop_checker
  import inv_loop_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DELAY_W     = 8,
  parameter int TIMEOUT     = 200,
  parameter int INVERTING   = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [7:0]         half_period,
  input  logic [7:0]         n_edges,
  output logic               stim_out,
  input  logic               resp_in,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [7:0]         err_count,
  output logic [DELAY_W-1:0] last_delay,
  output logic               timeout_flag,
  output logic [DELAY_W-1:0] max_delay
);

  // Counter is wide enough to hold both a full half period and TIMEOUT+1.
  localparam int CNT_W = ((DELAY_W > 8) ? DELAY_W : 8) + 1;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic             INV_BIT   = (INVERTING != 0);

  state_t           r_state;
  logic [7:0]       r_hp;
  logic [7:0]       r_edges;
  logic [CNT_W-1:0] r_dcnt;
  logic             w_resp_s;
  logic             w_match;
  logic             w_accept;
  logic [CNT_W-1:0] w_hp;

  inv_loop_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (resp_in),
    .q   (w_resp_s)
  );

  assign w_match  = (w_resp_s == (stim_out ^ INV_BIT));
  assign w_accept = (r_state == IDLE) && start;
  assign w_hp     = CNT_W'(r_hp);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_hp         <= 8'd0;
      r_edges      <= 8'd0;
      r_dcnt       <= '0;
      stim_out     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      err_count    <= 8'd0;
      last_delay   <= '0;
      timeout_flag <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_hp         <= (half_period == 8'd0) ? 8'd1 : half_period;
            r_edges      <= n_edges;
            r_dcnt       <= CNT_W'(1);
            err_count    <= 8'd0;
            timeout_flag <= 1'b0;
            pass         <= 1'b0;
            busy         <= 1'b1;
            stim_out     <= 1'b0;
            r_state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (r_dcnt >= w_hp) r_state <= (r_edges == 8'd0) ? FINISH : TOGGLE;
          else                r_dcnt  <= r_dcnt + CNT_W'(1);
        end
        TOGGLE: begin
          stim_out <= ~stim_out;
          r_dcnt   <= CNT_W'(1);
          r_edges  <= r_edges - 8'd1;
          r_state  <= MEASURE;
        end
        MEASURE: begin
          if (w_match) begin
            last_delay <= DELAY_W'(r_dcnt);
            r_dcnt     <= r_dcnt + CNT_W'(1);
            r_state    <= HOLD;
          end else if (r_dcnt == TIMEOUT_C) begin
            err_count    <= sat_inc(err_count);
            timeout_flag <= 1'b1;
            r_state      <= NEXT;
          end else begin
            r_dcnt <= r_dcnt + CNT_W'(1);
          end
        end
        // Stretch the half period when the loop is slower than requested.
        HOLD: begin
          if (r_dcnt >= w_hp) r_state <= NEXT;
          else                r_dcnt  <= r_dcnt + CNT_W'(1);
        end
        NEXT: begin
          r_state <= (r_edges == 8'd0) ? FINISH : TOGGLE;
        end
        FINISH: begin
          done     <= 1'b1;
          pass     <= (err_count == 8'd0);
          busy     <= 1'b0;
          stim_out <= 1'b0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef INV_LOOP_MAXDLY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      max_delay <= '0;
    end else if (w_accept) begin
      max_delay <= '0;
    end else if ((r_state == MEASURE) && w_match && (DELAY_W'(r_dcnt) > max_delay)) begin
      max_delay <= DELAY_W'(r_dcnt);
    end
  end
`else
  assign max_delay = '0;
`endif

endmodule
